// File: rtl/cnn_window_gen.sv
// 3x3 sliding-window generator: two line buffers plus a shift-register window over a raster pixel stream.
// Optional macro CNN_WINDOW_GEN_FRAME_DONE_EN adds o_frame_done, pulsed with the last window of a frame.
module cnn_window_gen #(
    parameter int IMG_W = 8,
    parameter int IMG_H = 8,
    parameter int IF_BW = 8,
    parameter int KW    = 3,
    parameter int KH    = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_valid,
    input  logic [IF_BW-1:0]             i_pixel,
    output logic                         o_valid,
    output logic [KW*KH*IF_BW-1:0]       o_fmap,
    output logic [$clog2(IMG_H)-1:0]     o_row,
    output logic [$clog2(IMG_W)-1:0]     o_col
`ifdef CNN_WINDOW_GEN_FRAME_DONE_EN
    ,
    output logic                         o_frame_done
`endif
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_TWO  = CW'(2);
    localparam logic [RW-1:0] ROW_ONE  = RW'(1);

    typedef enum logic {
        FILL,
        ACTIVE
    } state_t;

    state_t state, state_next;

    logic [CW-1:0]    col;
    logic [RW-1:0]    row;
    logic [IF_BW-1:0] line1 [IMG_W];
    logic [IF_BW-1:0] line2 [IMG_W];
    logic [IF_BW-1:0] win      [KH][KW];
    logic [IF_BW-1:0] win_next [KH][KW];
    logic [KW*KH*IF_BW-1:0] fmap_next;
    logic emit;
    logic last_pix;

    assign last_pix = i_valid && (row == ROW_LAST) && (col == COL_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col <= '0;
            row <= '0;
        end else if (i_valid) begin
            if (col == COL_LAST) begin
                col <= '0;
                row <= (row == ROW_LAST) ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= FILL;
        else      state <= state_next;
    end

    always_comb begin
        state_next = state;
        emit       = 1'b0;
        case (state)
            FILL: begin
                if (i_valid && (row == ROW_ONE) && (col == COL_LAST))
                    state_next = ACTIVE;
            end
            ACTIVE: begin
                // ACTIVE covers rows 2..IMG_H-1, so only the column test remains
                emit = i_valid && (col >= COL_TWO);
                if (last_pix)
                    state_next = FILL;
            end
            default: state_next = FILL;
        endcase
    end

    // Line buffers are never reset; FILL overwrites both rows before any window is emitted
    always_ff @(posedge clk) begin
        if (i_valid) begin
            line2[col] <= line1[col];
            line1[col] <= i_pixel;
        end
    end

    always_comb begin
        win_next  = win;
        fmap_next = '0;
        if (i_valid) begin
            for (int unsigned r = 0; r < KH; r++) begin
                win_next[r][0] = win[r][1];
                win_next[r][1] = win[r][2];
            end
            win_next[0][2] = line2[col];
            win_next[1][2] = line1[col];
            win_next[2][2] = i_pixel;
        end
        for (int unsigned r = 0; r < KH; r++)
            for (int unsigned c = 0; c < KW; c++)
                fmap_next[(r*KW + c)*IF_BW +: IF_BW] = win_next[r][c];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned r = 0; r < KH; r++)
                for (int unsigned c = 0; c < KW; c++)
                    win[r][c] <= '0;
            o_valid <= 1'b0;
            o_fmap  <= '0;
            o_row   <= '0;
            o_col   <= '0;
        end else begin
            win     <= win_next;
            o_valid <= emit;
            if (emit) begin
                o_fmap <= fmap_next;
                o_row  <= row;
                o_col  <= col;
            end
        end
    end

`ifdef CNN_WINDOW_GEN_FRAME_DONE_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) o_frame_done <= 1'b0;
        else      o_frame_done <= emit && last_pix;
    end
`endif

endmodule

// File: tb/tb_cnn_window_gen.sv
// Directed bench for cnn_window_gen: reset, full frames, gapped back-to-back frames, mid-frame reset.
// Define CNN_WINDOW_GEN_FRAME_DONE_EN to also check o_frame_done.
module tb_cnn_window_gen;

    localparam int IMG_W = 8;
    localparam int IMG_H = 8;
    localparam int IF_BW = 8;

    localparam logic [71:0] FIRST_WIN = {8'd19, 8'd18, 8'd17, 8'd11, 8'd10, 8'd9, 8'd3, 8'd2, 8'd1};
    localparam logic [71:0] LAST_WIN  = {8'd64, 8'd63, 8'd62, 8'd56, 8'd55, 8'd54, 8'd48, 8'd47, 8'd46};

    logic             clk;
    logic             rst;
    logic             i_valid;
    logic [IF_BW-1:0] i_pixel;
    logic             o_valid;
    logic [71:0]      o_fmap;
    logic [2:0]       o_row;
    logic [2:0]       o_col;
`ifdef CNN_WINDOW_GEN_FRAME_DONE_EN
    logic             o_frame_done;
`endif

    int n_checks;
    int n_errors;
    int tr;
    int tc;
    int win_cnt;

    cnn_window_gen #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H),
        .IF_BW (IF_BW),
        .KW    (3),
        .KH    (3)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .i_valid      (i_valid),
        .i_pixel      (i_pixel),
        .o_valid      (o_valid),
        .o_fmap       (o_fmap),
        .o_row        (o_row),
        .o_col        (o_col)
`ifdef CNN_WINDOW_GEN_FRAME_DONE_EN
        ,
        .o_frame_done (o_frame_done)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [71:0] model_win(input int r, input int c);
        logic [71:0] m;
        m = '0;
        for (int dr = 0; dr < 3; dr++)
            for (int dc = 0; dc < 3; dc++)
                m[(dr*3 + dc)*8 +: 8] = 8'((r - 2 + dr)*IMG_W + (c - 2 + dc) + 1);
        return m;
    endfunction

    task automatic check_idle_zero(input string tag);
        check_eq({tag, "_valid"}, 72'(o_valid), 72'(0));
        check_eq({tag, "_fmap"},  o_fmap,       72'(0));
        check_eq({tag, "_row"},   72'(o_row),   72'(0));
        check_eq({tag, "_col"},   72'(o_col),   72'(0));
    endtask

    // One clock: present a pixel (or a gap), then check the registered output one edge later
    task automatic step(input logic v);
        logic exp_v;
        exp_v   = v && (tr >= 2) && (tc >= 2);
        i_valid = v;
        i_pixel = v ? 8'(tr*IMG_W + tc + 1) : 8'($urandom);
        @(posedge clk);
        #1;
        check_eq("o_valid", 72'(o_valid), 72'(exp_v));
        if (exp_v) begin
            win_cnt++;
            check_eq("o_fmap", o_fmap, model_win(tr, tc));
            check_eq("o_row", 72'(o_row), 72'(tr));
            check_eq("o_col", 72'(o_col), 72'(tc));
            if (tr == 2 && tc == 2) check_eq("first_win", o_fmap, FIRST_WIN);
            if (tr == 7 && tc == 7) check_eq("last_win", o_fmap, LAST_WIN);
        end
`ifdef CNN_WINDOW_GEN_FRAME_DONE_EN
        check_eq("frame_done", 72'(o_frame_done), 72'(exp_v && tr == IMG_H-1 && tc == IMG_W-1));
`endif
        if (v) begin
            if (tc == IMG_W-1) begin
                tc = 0;
                tr = (tr == IMG_H-1) ? 0 : tr + 1;
            end else begin
                tc = tc + 1;
            end
        end
    endtask

    task automatic send_frame(input bit gaps, input string tag);
        win_cnt = 0;
        for (int idx = 0; idx < IMG_W*IMG_H; idx++) begin
            if (gaps && (idx % 3 == 2)) step(1'b0);
            step(1'b1);
        end
        check_eq({tag, "_win_count"}, 72'(win_cnt), 72'(36));
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        tr       = 0;
        tc       = 0;
        win_cnt  = 0;
        rst      = 1'b0;
        i_valid  = 1'b0;
        i_pixel  = '0;

        for (int i = 0; i < 6; i++) begin
            i_valid = 1'(i % 2);
            i_pixel = 8'($urandom);
            @(posedge clk);
            #1;
            check_idle_zero("in_reset");
        end

        rst     = 1'b1;
        i_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check_idle_zero("post_reset");
        end

        send_frame(1'b0, "frame1");
        send_frame(1'b1, "gap_frame_a");
        send_frame(1'b1, "gap_frame_b");

        for (int i = 0; i < 30; i++) step(1'b1);
        rst     = 1'b0;
        i_valid = 1'b0;
        @(posedge clk);
        #1;
        check_idle_zero("mid_reset");
        rst = 1'b1;
        tr  = 0;
        tc  = 0;
        send_frame(1'b0, "after_reset");

        step(1'b0);
        step(1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/cnn_window_gen.md
Name: cnn_window_gen

Overview:
- Upstream neighbour of cnn_kernel.
- Accepts a raster-order pixel stream, one IF_BW-bit pixel per valid cycle, and buffers two image lines internally.
- Emits every fully-interior 3x3 window as a packed 72-bit word (at defaults) with a valid strobe.
- o_fmap/o_valid connect directly to cnn_kernel i_fmap/i_valid. No backpressure exists on either side.

Parameters:
- IMG_W, 8, image width in pixels (>=3)
- IMG_H, 8, image height in pixels (>=3)
- IF_BW, 8, pixel width in bits
- KW, 3, window width (fixed at 3; other values unsupported)
- KH, 3, window height (fixed at 3; other values unsupported)

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  reset, asynchronous, active-low
- i_valid  input  1  i_pixel carries a pixel this cycle
- i_pixel  input  IF_BW  pixel value, raster order (row-major, left to right)
- o_valid  output  1  o_fmap holds a complete window this cycle
- o_fmap  output  KW*KH*IF_BW  packed 3x3 window
- o_row  output  clog2(IMG_H)  row index of the window's bottom-right pixel
- o_col  output  clog2(IMG_W)  column index of the window's bottom-right pixel

Behaviour:
- Reset (rst=0, asynchronous):
  - o_valid=0, o_fmap=0, o_row=0, o_col=0.
  - Column/row counters=0; state=FILL.
  - Line-buffer RAM contents are not cleared; FILL guarantees they are overwritten before use.
- Counters:
  - col/row advance only on accepted pixels (i_valid=1).
  - col wraps IMG_W-1 -> 0 and increments row.
  - At (IMG_H-1, IMG_W-1), row and col both wrap to 0. The next pixel starts a new frame with no idle cycle required.
- Storage:
  - Two line buffers of depth IMG_W (line1 = previous row, line2 = row before that), addressed by col.
  - A 3x3 shift-register window. On each accepted pixel, every window row shifts left by one column.
  - The new right column is {line2[col], line1[col], i_pixel}. Then line2[col]<=line1[col] and line1[col]<=i_pixel.
- State machine:
  - FILL: row<2. Shift and buffer only; o_valid is never asserted.
  - FILL -> ACTIVE when a pixel is accepted at col=IMG_W-1, row=1.
  - ACTIVE: rows 2..IMG_H-1.
  - ACTIVE -> FILL when the last pixel of the frame is accepted.
- Output:
  - Registered, latency 1 cycle: o_valid=1 in the cycle after an accepted pixel with row>=2 and col>=2.
  - o_row/o_col are the coordinates of that accepted pixel.
  - In all other cycles o_valid=0. o_fmap holds its last value.
- Packing:
  - Element k=r*3+c, where r=0 is the top row and c=0 the leftmost column, occupies o_fmap[k*IF_BW +: IF_BW].
  - The top-left (oldest) pixel is in the LSBs and the bottom-right (newest) pixel in the MSBs.
- Window count: (IMG_W-2)*(IMG_H-2) windows per frame, 36 at defaults. No padding; edge windows are never emitted.
- Row boundary: windows straddling a row wrap (col<2) are suppressed, even though the shift register holds stale columns.
- i_valid gaps: the state is frozen; windows are unaffected except for timing.
- Reset mid-frame: all state returns to the reset values. The next accepted pixel is treated as (0,0) of a new frame.

Optional Feature:
- Macro: CNN_WINDOW_GEN_FRAME_DONE_EN
- When defined: adds output port o_frame_done (1 bit, reset 0). It pulses high for exactly one cycle, coincident with o_valid, for the final window of a frame (o_row=IMG_H-1, o_col=IMG_W-1).
- When undefined: the port and its logic are absent. All other behaviour is identical.

Test Plan:
- Reset: hold rst=0 with i_valid toggling -> o_valid=0, o_fmap=0 throughout. Release rst -> outputs stay 0 until a pixel is accepted.
- First window: stream 64 pixels, value = index+1 (1..64), i_valid continuous -> the first o_valid occurs the cycle after pixel 19 (row2, col2). o_fmap elements 0..8 = 1,2,3,9,10,11,17,18,19; o_row=2, o_col=2.
- Frame count: same stream -> exactly 36 o_valid pulses. The last has o_row=7, o_col=7, elements = 46,47,48,54,55,56,62,63,64. No pulse follows pixels at col 0/1 of rows 2..7.
- Gaps plus back-to-back frames: repeat the stream with i_valid=0 inserted every third cycle, then immediately send a second frame -> identical 36 windows per frame. The second frame's first window has the same contents as in the first-window test.
- Mid-frame reset: assert rst=0 for one cycle after pixel 30, then send a full fresh frame -> no window mixes old data. The first window after reset is again 1,2,3,9,10,11,17,18,19.
- With CNN_WINDOW_GEN_FRAME_DONE_EN: o_frame_done is high only in the cycle of the 36th window. Without the macro, the build compiles and behaviour is otherwise unchanged.
